// File: rtl/upstream_aligner.sv
// Source-to-destination byte realigner: fetches qwords from an arbitrary source
// offset and emits qwords shifted and masked to the destination offset.
module upstream_aligner (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busif_start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] byte_length,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_gnt,
  input  logic [63:0] rd_data,
  input  logic        rd_data_en,
  output logic [63:0] aligner_data,
  output logic        aligner_data_en,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [3:0]  p_q, p_d;
  logic [2:0]  do_q, do_d;
  logic [3:0]  end_q, end_d;
  logic        prime_q, prime_d;
  logic [16:0] n_in_q, n_in_d, n_out_q, n_out_d;
  logic [16:0] rd_cnt_q, rd_cnt_d, rx_cnt_q, rx_cnt_d, out_cnt_q, out_cnt_d;
  logic [16:0] outst_q, outst_d;
  logic [63:0] prev_q, prev_d;
  logic        rd_req_q, rd_req_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [63:0] data_q, data_d;
  logic        data_en_q, data_en_d;
  logic        busy_q, busy_d;

  logic [2:0]  so_s, dof_s, end_low_s;
  logic [16:0] n_in_s, n_out_s;
  logic [3:0]  p_s;
  logic        grant_s, ret_s, emit_s;

  // Byte lane b of the result is byte (p+b) of {cur, prev}.
  function automatic logic [63:0] align_word(input logic [63:0] cur,
                                             input logic [63:0] prev,
                                             input logic [3:0]  p);
    logic [127:0] s;
    s = {cur, prev} >> {p, 3'b000};
    return s[63:0];
  endfunction

  function automatic logic [63:0] lane_mask(input logic       first,
                                            input logic       last,
                                            input logic [2:0] dof,
                                            input logic [3:0] lim);
    logic [63:0] m;
    m = 64'd0;
    for (int b = 0; b < 8; b++) begin
      if ((first && (4'(b) < {1'b0, dof})) || (last && (4'(b) >= lim))) begin
        m[8*b +: 8] = 8'h00;
      end else begin
        m[8*b +: 8] = 8'hFF;
      end
    end
    return m;
  endfunction

  assign so_s      = src_addr[2:0];
  assign dof_s     = dst_addr[2:0];
  assign n_in_s    = ({14'd0, so_s} + {1'b0, byte_length} + 17'd7) >> 3;
  assign n_out_s   = ({14'd0, dof_s} + {1'b0, byte_length} + 17'd7) >> 3;
  assign p_s       = (so_s > dof_s) ? ({1'b0, so_s} - {1'b0, dof_s})
                                    : (4'd8 + {1'b0, so_s} - {1'b0, dof_s});
  assign end_low_s = dof_s + byte_length[2:0] - 3'd1;
  assign grant_s   = rd_req_q & rd_gnt;
  // Returns with nothing outstanding (stale or post-reset) are dropped here.
  assign ret_s     = rd_data_en & (outst_q != 17'd0);

  // Next-state, read sequencing and output datapath.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    p_d       = p_q;
    do_d      = do_q;
    end_d     = end_q;
    prime_d   = prime_q;
    n_in_d    = n_in_q;
    n_out_d   = n_out_q;
    rd_cnt_d  = rd_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    out_cnt_d = out_cnt_q;
    prev_d    = prev_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    data_d    = 64'd0;
    data_en_d = 1'b0;
    emit_s    = 1'b0;

    if (grant_s && !ret_s) begin
      outst_d = outst_q + 17'd1;
    end else if (!grant_s && ret_s) begin
      outst_d = outst_q - 17'd1;
    end else begin
      outst_d = outst_q;
    end

    if (!busif_start) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      S_IDLE: begin
        rd_req_d = 1'b0;
        // A start seen during an abort drain waits until the drain empties.
        if (busif_start && armed_q && (outst_q == 17'd0)) begin
          armed_d   = 1'b0;
          p_d       = p_s;
          do_d      = dof_s;
          end_d     = {1'b0, end_low_s} + 4'd1;
          prime_d   = (so_s > dof_s);
          n_in_d    = n_in_s;
          n_out_d   = n_out_s;
          rd_cnt_d  = 17'd0;
          rx_cnt_d  = 17'd0;
          out_cnt_d = 17'd0;
          prev_d    = 64'd0;
          if (byte_length == 16'd0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RUN;
            rd_req_d  = 1'b1;
            rd_addr_d = {src_addr[31:3], 3'b000};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!busif_start) begin
          state_d  = S_IDLE;
          rd_req_d = 1'b0;
        end else begin
          if (grant_s) begin
            rd_cnt_d  = rd_cnt_q + 17'd1;
            rd_addr_d = rd_addr_q + 32'd8;
            rd_req_d  = (rd_cnt_q + 17'd1) < n_in_q;
          end else begin
            rd_req_d = rd_req_q;
          end
          if (ret_s) begin
            prev_d   = rd_data;
            rx_cnt_d = rx_cnt_q + 17'd1;
            emit_s   = !(prime_q && (rx_cnt_q == 17'd0));
            if (emit_s) begin
              data_d    = align_word(rd_data, prev_q, p_q) &
                          lane_mask(out_cnt_q == 17'd0, out_cnt_q == (n_out_q - 17'd1), do_q, end_q);
              data_en_d = 1'b1;
              out_cnt_d = out_cnt_q + 17'd1;
            end else begin
              out_cnt_d = out_cnt_q;
            end
            if ((rx_cnt_q + 17'd1) == n_in_q) begin
              state_d = (out_cnt_d == n_out_q) ? S_DONE : S_FLUSH;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_FLUSH: begin
        if (!busif_start) begin
          state_d = S_IDLE;
        end else begin
          data_d    = align_word(64'd0, prev_q, p_q) &
                      lane_mask(out_cnt_q == 17'd0, out_cnt_q == (n_out_q - 17'd1), do_q, end_q);
          data_en_d = 1'b1;
          out_cnt_d = out_cnt_q + 17'd1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (!busif_start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rd_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE) || (outst_d != 17'd0);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b0;
      p_q       <= 4'd0;
      do_q      <= 3'd0;
      end_q     <= 4'd0;
      prime_q   <= 1'b0;
      n_in_q    <= 17'd0;
      n_out_q   <= 17'd0;
      rd_cnt_q  <= 17'd0;
      rx_cnt_q  <= 17'd0;
      out_cnt_q <= 17'd0;
      outst_q   <= 17'd0;
      prev_q    <= 64'd0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= 32'd0;
      data_q    <= 64'd0;
      data_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      p_q       <= p_d;
      do_q      <= do_d;
      end_q     <= end_d;
      prime_q   <= prime_d;
      n_in_q    <= n_in_d;
      n_out_q   <= n_out_d;
      rd_cnt_q  <= rd_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      out_cnt_q <= out_cnt_d;
      outst_q   <= outst_d;
      prev_q    <= prev_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      data_en_q <= data_en_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_req          = rd_req_q;
  assign rd_addr         = rd_addr_q;
  assign aligner_data    = data_q;
  assign aligner_data_en = data_en_q;
  assign busy            = busy_q;

endmodule
